// File: rtl/bitstream_pkg.sv
// Types and constants shared by the bitstream scheduler and its stochastic number generator.
package bitstream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // x^8+x^6+x^5+x^4+1, as a mask over a left-shifting Fibonacci register.
  localparam logic [7:0] LFSR_TAPS_8  = 8'hB8;
  localparam logic [7:0] SEED_DEFAULT = 8'h01;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      16:      return 32'h0000_D008;
      default: return {24'h0, LFSR_TAPS_8};
    endcase
  endfunction

endpackage

// File: rtl/bitstream_scheduler_if.sv
// Start/busy/done handshake plus bitstream datapath signals of the bitstream scheduler.
interface bitstream_scheduler_if #(
  parameter int N_IN       = 2,
  parameter int DATA_W     = 8,
  parameter int STREAM_LEN = 255
);
  localparam int RES_W = $clog2(STREAM_LEN + 1);

  logic                         start;
  logic [N_IN-1:0][DATA_W-1:0]  in_value;
  logic                         busy;
  logic                         done;
  logic [N_IN-1:0]              bs_out;
  logic                         bs_valid;
  logic                         bs_in;
  logic [RES_W-1:0]             result;

  modport master (
    output start, in_value, bs_in,
    input  busy, done, bs_out, bs_valid, result
  );

  modport slave (
    input  start, in_value, bs_in,
    output busy, done, bs_out, bs_valid, result
  );

endinterface

// File: rtl/bitstream_sng.sv
// LFSR-plus-comparator stochastic number generator, one comparator per channel.
// BITSTREAM_DECORRELATE_EN rotates each channel's view of the shared LFSR.
module bitstream_sng
  import bitstream_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        en,
  input  logic [N_IN-1:0][DATA_W-1:0] value,
  output logic [N_IN-1:0]             bits
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [DATA_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & TAPS)};
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    logic [DATA_W-1:0] view;
`ifdef BITSTREAM_DECORRELATE_EN
    localparam int SH = (i * (DATA_W / N_IN)) % DATA_W;
    logic [2*DATA_W-1:0] dbl;
    // Upper half of the shifted doubled word is the left rotation.
    assign dbl  = {lfsr, lfsr} << SH;
    assign view = dbl[2*DATA_W-1 -: DATA_W];
`else
    assign view = lfsr;
`endif
    assign bits[i] = value[i] > view;
  end

endmodule

// File: rtl/bitstream_scheduler.sv
// Runs one stochastic evaluation: latch inputs, stream STREAM_LEN bits, count network ones.
// Optional BITSTREAM_DECORRELATE_EN is handled inside bitstream_sng.
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// RUN   | STREAM_LEN cycles of live bitstreams, LFSR stepping
// FLUSH | LATENCY cycles draining the network pipeline
// DONE  | one-cycle done pulse, result just updated
module bitstream_scheduler
  import bitstream_pkg::*;
#(
  parameter int                N_IN       = 2,
  parameter int                DATA_W     = 8,
  parameter int                STREAM_LEN = 255,
  parameter int                LATENCY    = 2,
  parameter logic [DATA_W-1:0] SEED       = DATA_W'(SEED_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  bitstream_scheduler_if.slave bus
);

  localparam int RES_W = $clog2(STREAM_LEN + 1);
  localparam int TMR_W = $clog2(STREAM_LEN + LATENCY + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STREAM_LEN + LATENCY - 1);
  localparam logic [TMR_W-1:0] RUN_END  = TMR_W'(LATENCY);
  localparam logic [TMR_W-1:0] WIN_TOP  = TMR_W'(STREAM_LEN);

  state_t                      state_q, state_d;
  logic [TMR_W-1:0]            tmr_q;
  logic [RES_W-1:0]            ones_q, ones_nxt, result_q;
  logic [N_IN-1:0][DATA_W-1:0] in_q;
  logic [N_IN-1:0]             sng_bits;
  logic                        load, step, active, sampling;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (tmr_q == RUN_END) state_d = (LATENCY == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (tmr_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One timer spans RUN and FLUSH; its low STREAM_LEN values form the count window.
  assign active   = (state_q == RUN) || (state_q == FLUSH);
  assign sampling = active && (tmr_q < WIN_TOP);
  assign ones_nxt = ones_q + RES_W'(sampling & bus.bs_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
      in_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        tmr_q  <= TMR_LOAD;
        ones_q <= '0;
        in_q   <= bus.in_value;
      end else begin
        if (active) tmr_q <= tmr_q - TMR_W'(1);
        ones_q <= ones_nxt;
        if (state_d == DONE) result_q <= ones_nxt;
      end
    end
  end

  bitstream_sng #(
    .N_IN   (N_IN),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_sng (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (step),
    .value (in_q),
    .bits  (sng_bits)
  );

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.bs_valid = (state_q == RUN);
  assign bus.bs_out   = (state_q == RUN) ? sng_bits : '0;
  assign bus.result   = result_q;

endmodule

// File: doc/bitstream_scheduler.md
Name: bitstream_scheduler

Overview:
Sequences one stochastic-computing evaluation of the bitstream network. On start it latches N_IN unsigned probability words and converts them to unipolar bitstreams with an LFSR-plus-comparator stochastic number generator (SNG). It drives those bitstreams into the network for STREAM_LEN cycles, then counts the ones on the network's output bitstream to form the result. It sits between network_control's data registers and the bitstream datapath, and owns the start/busy/done handshake.

Parameters:
N_IN, 2, number of input channels / bitstreams
DATA_W, 8, probability word width; LFSR width equals DATA_W
STREAM_LEN, 255, bitstream length in cycles (full LFSR period at DATA_W=8)
LATENCY, 2, network pipeline depth in cycles between bs_out and the matching bs_in
SEED, 8'h01, LFSR reload value; must be nonzero

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin an evaluation
in_value  in  N_IN x DATA_W  probability words, value/2^DATA_W
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when result is valid
bs_out  out  N_IN  stochastic bitstreams to the network
bs_valid  out  1  high while bs_out carries live stream bits
bs_in  in  1  network output bitstream
result  out  $clog2(STREAM_LEN+1)  ones count of bs_in over the window

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; busy, done, bs_out, bs_valid and result are all 0; LFSR=SEED; counters cleared.
  - Applies mid-run too: the run is aborted with no done pulse.
- FSM states:
  - IDLE: start=1 latches in_value into internal registers, reloads LFSR=SEED, clears ones count and cycle count, goes to RUN. Same-edge start behaviour is required: if start is sampled in IDLE, busy rises on the next cycle.
  - RUN: lasts exactly STREAM_LEN cycles with bs_valid=1.
    - Each cycle, bs_out[i] = (in_value_q[i] > lfsr_view[i]).
    - LFSR is a maximal-length Fibonacci LFSR stepping every cycle, period 2^DATA_W-1, values 1..2^DATA_W-1.
    - After STREAM_LEN cycles, go to FLUSH.
  - FLUSH: lasts exactly LATENCY cycles; bs_valid=0 and bs_out=0.
  - DONE: one cycle; done=1; result updated; then back to IDLE, busy=0.
- Count window: bs_in is sampled in the LATENCY..STREAM_LEN+LATENCY-1 cycles after RUN entry, i.e. exactly STREAM_LEN samples aligned to bs_out.
  - The count cannot overflow: width is $clog2(STREAM_LEN+1).
- Total latency: start to done is 1+STREAM_LEN+LATENCY cycles.
- start while busy is ignored; in_value changes while busy are ignored.
- result holds its value until the next DONE or rst; it is not cleared on start.
- Boundary values at DATA_W=8, shared LFSR, STREAM_LEN=255: in_value=v gives exactly max(v-1,0) ones on the stream.
  - v=0 gives an all-zero stream.
  - v=255 gives 254 ones.
- LATENCY=0 is legal: FLUSH is skipped and RUN goes straight to DONE.

Optional Feature:
BITSTREAM_DECORRELATE_EN
- Undefined: every channel uses lfsr_view[i] = lfsr. Streams are fully correlated; an AND-gate network computes min(a,b).
- Defined: lfsr_view[i] = lfsr rotated left by i*(DATA_W/N_IN) bits. Streams are decorrelated; an AND-gate network approximates a*b.
- Per-channel ones counts are identical in both modes, because rotation is a permutation over the period.

Decomposition:
- Shared package bitstream_pkg holds:
  - state_t enum {IDLE, RUN, FLUSH, DONE};
  - the LFSR tap-mask constant for DATA_W=8 (x^8+x^6+x^5+x^4+1);
  - the default SEED.
- One sub-module, bitstream_sng: holds the LFSR, per-channel views and comparators, with a load/enable interface. The scheduler FSM and counters stay in bitstream_scheduler.

Test Plan:
- Identity network (bs_in = bs_out[0] delayed LATENCY), in_value[0]=128, start -> done exactly 258 cycles later (1+255+2), result=127.
- Identity network, in_value[0]=0, then a second run with 255 -> result=0 then 254; busy low between runs; result holds 0 until the second done.
- AND network (bs_in = bs_out[0] & bs_out[1]), 128/128, macro undefined -> result=127; with BITSTREAM_DECORRELATE_EN -> result in 48..80 and not 127.
- start pulsed again at cycle 50 of RUN with new in_value -> ignored; done still at cycle 258; result reflects the original inputs.
- rst asserted at cycle 100 of RUN -> next cycle busy=0, bs_valid=0, result=0, no done pulse; a following start runs normally with the correct result.
- LATENCY=0 build, identity network wired without delay, in_value=200 -> done at cycle 256, result=199.
